// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive frame parser.
package uart_pkg;

    typedef enum logic [2:0] {
        HUNT,
        ADDR,
        LEN,
        PAYLOAD,
        CSUM
    } parse_state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_CSUM    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hAA;

endpackage

// File: rtl/uart_rx_frame_parser_if.sv
// FIFO read port, RAM write port and frame status of the frame parser.
interface uart_rx_frame_parser_if;

    logic       fifo_rdempty;
    logic [7:0] fifo_q;
    logic       fifo_rdreq;
    logic [7:0] ram_addr;
    logic [7:0] ram_data;
    logic       ram_wren;
    logic       frame_done;
    logic       frame_err;
    logic [1:0] err_code;
    logic [7:0] frame_cnt;

    modport master (
        input  fifo_rdempty,
        input  fifo_q,
        output fifo_rdreq,
        output ram_addr,
        output ram_data,
        output ram_wren,
        output frame_done,
        output frame_err,
        output err_code,
        output frame_cnt
    );

    modport slave (
        output fifo_rdempty,
        output fifo_q,
        input  fifo_rdreq,
        input  ram_addr,
        input  ram_data,
        input  ram_wren,
        input  frame_done,
        input  frame_err,
        input  err_code,
        input  frame_cnt
    );

endinterface

// File: rtl/uart_fifo_rd_if.sv
// FIFO read engine: one outstanding read, byte presented the cycle after rdreq.
module uart_fifo_rd_if (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_rdempty,
    input  logic [7:0] fifo_q,
    output logic       fifo_rdreq,
    output logic [7:0] rx_byte,
    output logic       rx_vld
);

    logic pending;

    // Holding off while a read is in flight keeps the FIFO from being popped twice per byte.
    assign fifo_rdreq = !rst && !fifo_rdempty && !pending;
    assign rx_vld     = pending;
    assign rx_byte    = fifo_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else begin
            pending <= fifo_rdreq;
        end
    end

endmodule

// File: rtl/uart_rx_frame_parser.sv
// Parses SYNC/ADDR/LEN/PAYLOAD/CSUM frames from the receive FIFO into RAM.
// Optional inter-byte timeout enabled by defining UART_RX_FRAME_TIMEOUT_EN.
module uart_rx_frame_parser
    import uart_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         MAX_LEN        = 64,
    parameter int         TIMEOUT_CYCLES = 48000
) (
    input logic                    clk,
    input logic                    rst,
    uart_rx_frame_parser_if.master bus
);

    logic [7:0]   rx_byte;
    logic         rx_vld;

    parse_state_t state, state_n;
    logic [7:0]   base, base_n;
    logic [7:0]   len, len_n;
    logic [7:0]   idx, idx_n;
    logic [7:0]   csum, csum_n;
    logic [7:0]   ram_addr_q, ram_addr_n;
    logic [7:0]   ram_data_q, ram_data_n;
    logic         ram_wren_q, ram_wren_n;
    logic         done_q, done_n;
    logic         err_q, err_n;
    logic [1:0]   code_q, code_n;
    logic [7:0]   cnt_q, cnt_n;

    uart_fifo_rd_if u_rd (
        .clk          (clk),
        .rst          (rst),
        .fifo_rdempty (bus.fifo_rdempty),
        .fifo_q       (bus.fifo_q),
        .fifo_rdreq   (bus.fifo_rdreq),
        .rx_byte      (rx_byte),
        .rx_vld       (rx_vld)
    );

    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_data   = ram_data_q;
    assign bus.ram_wren   = ram_wren_q;
    assign bus.frame_done = done_q;
    assign bus.frame_err  = err_q;
    assign bus.err_code   = code_q;
    assign bus.frame_cnt  = cnt_q;

`ifdef UART_RX_FRAME_TIMEOUT_EN
    logic [31:0] tmo_cnt, tmo_cnt_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= 32'd0;
        end else begin
            tmo_cnt <= tmo_cnt_n;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HUNT;
            base       <= 8'd0;
            len        <= 8'd0;
            idx        <= 8'd0;
            csum       <= 8'd0;
            ram_addr_q <= 8'd0;
            ram_data_q <= 8'd0;
            ram_wren_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            code_q     <= ERR_NONE;
            cnt_q      <= 8'd0;
        end else begin
            state      <= state_n;
            base       <= base_n;
            len        <= len_n;
            idx        <= idx_n;
            csum       <= csum_n;
            ram_addr_q <= ram_addr_n;
            ram_data_q <= ram_data_n;
            ram_wren_q <= ram_wren_n;
            done_q     <= done_n;
            err_q      <= err_n;
            code_q     <= code_n;
            cnt_q      <= cnt_n;
        end
    end

    // The FSM only moves on a captured byte; an empty FIFO simply stalls it.
    always_comb begin
        state_n    = state;
        base_n     = base;
        len_n      = len;
        idx_n      = idx;
        csum_n     = csum;
        ram_addr_n = ram_addr_q;
        ram_data_n = ram_data_q;
        ram_wren_n = 1'b0;
        done_n     = 1'b0;
        err_n      = 1'b0;
        code_n     = code_q;
        cnt_n      = cnt_q;

        if (rx_vld) begin
            unique case (state)
                HUNT: begin
                    if (rx_byte == SYNC_BYTE) state_n = ADDR;
                end
                ADDR: begin
                    base_n  = rx_byte;
                    csum_n  = rx_byte;
                    state_n = LEN;
                end
                LEN: begin
                    csum_n = csum ^ rx_byte;
                    if (rx_byte == 8'd0) begin
                        state_n = CSUM;
                    end else if (rx_byte > 8'(MAX_LEN)) begin
                        err_n   = 1'b1;
                        code_n  = ERR_LEN;
                        state_n = HUNT;
                    end else begin
                        len_n   = rx_byte;
                        idx_n   = 8'd0;
                        state_n = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    ram_wren_n = 1'b1;
                    ram_addr_n = base + idx;
                    ram_data_n = rx_byte;
                    csum_n     = csum ^ rx_byte;
                    idx_n      = idx + 8'd1;
                    if (idx == len - 8'd1) state_n = CSUM;
                end
                CSUM: begin
                    if (rx_byte == csum) begin
                        done_n = 1'b1;
                        code_n = ERR_NONE;
                        cnt_n  = cnt_q + 8'd1;
                    end else begin
                        err_n  = 1'b1;
                        code_n = ERR_CSUM;
                    end
                    state_n = HUNT;
                end
                default: state_n = HUNT;
            endcase
        end

`ifdef UART_RX_FRAME_TIMEOUT_EN
        tmo_cnt_n = 32'd0;
        if (state != HUNT && !rx_vld) begin
            if (tmo_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                err_n   = 1'b1;
                code_n  = ERR_TIMEOUT;
                state_n = HUNT;
            end else begin
                tmo_cnt_n = tmo_cnt + 32'd1;
            end
        end
`endif
    end

endmodule
